// File: rtl/msdap_serial_rx.sv
// -----------------------------------------------------------------------------
// msdap_serial_rx
// Bit-serial input front end for the MSDAP stereo FIR core.
// Dclk/Frame/InputL/InputR are synchronised into the Sclk domain. The block
// assembles 16-bit left/right words, MSB first, on Dclk falling edges. Each
// completed word pair is issued with a one-cycle WordValid strobe. WordType
// and Index say where the pair sits in the Rj -> coefficient -> data load
// sequence.
// Optional feature: define ZERO_DETECT_EN to enable the zero-run Sleep
// detector. When it is undefined, Sleep is tied low. The port list is the
// same in both builds.
// -----------------------------------------------------------------------------
module msdap_serial_rx #(
    parameter int WORD_W      = 16,
    parameter int NUM_RJ      = 16,
    parameter int NUM_COEF    = 512,
    parameter int SYNC_STAGES = 2,
    parameter int ZERO_RUN    = 800
) (
    input  logic              Sclk,
    input  logic              Reset_n,
    input  logic              Start,
    input  logic              Dclk,
    input  logic              Frame,
    input  logic              InputL,
    input  logic              InputR,
    output logic [WORD_W-1:0] WordL,
    output logic [WORD_W-1:0] WordR,
    output logic              WordValid,
    output logic [1:0]        WordType,
    output logic [8:0]        Index,
    output logic              FrameErr,
    output logic              Sleep
);

    localparam int              BC_W     = $clog2(WORD_W + 1);
    localparam logic [BC_W-1:0] BC_FULL  = BC_W'(WORD_W);
    localparam logic [BC_W-1:0] BC_LAST  = BC_W'(WORD_W - 1);
    localparam logic [8:0]      RJ_LAST  = 9'(NUM_RJ - 1);
    localparam logic [8:0]      COEF_LAST = 9'(NUM_COEF - 1);

    typedef enum logic [1:0] {
        PH_RJ   = 2'b00,
        PH_COEF = 2'b01,
        PH_DATA = 2'b10
    } phase_t;

    // ------------------------------------------------------------------
    // Input synchroniser: all four serial lines move through the chain
    // together, so Frame and data stay aligned with the Dclk they belong to.
    // ------------------------------------------------------------------
    logic [3:0] sync_out;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            logic [3:0] stage_q;
            if (gi == 0) begin : g_first
                // First stage captures the raw asynchronous lines.
                always_ff @(posedge Sclk or negedge Reset_n) begin
                    if (!Reset_n) stage_q <= '0;
                    else          stage_q <= {Dclk, Frame, InputL, InputR};
                end
            end else begin : g_next
                // Later stages move the previous stage along.
                always_ff @(posedge Sclk or negedge Reset_n) begin
                    if (!Reset_n) stage_q <= '0;
                    else          stage_q <= g_sync[gi-1].stage_q;
                end
            end
        end
    endgenerate

    assign sync_out = g_sync[SYNC_STAGES-1].stage_q;

    logic dclk_s, frame_s, in_l_s, in_r_s;
    assign {dclk_s, frame_s, in_l_s, in_r_s} = sync_out;

    logic dclk_prev_q;
    logic strobe;

    // Remember the synced Dclk level so that a falling edge can be detected.
    always_ff @(posedge Sclk or negedge Reset_n) begin
        if (!Reset_n) dclk_prev_q <= 1'b0;
        else          dclk_prev_q <= dclk_s;
    end

    // Source data changes on Dclk rising edges. The falling edge is the
    // mid-bit point where the data is stable.
    assign strobe = dclk_prev_q & ~dclk_s;

    // ------------------------------------------------------------------
    // Word assembly and phase FSM
    // ------------------------------------------------------------------
    logic [BC_W-1:0]   bc_q, bc_d;
    logic [WORD_W-1:0] shl_q, shl_d, shr_q, shr_d;
    logic [WORD_W-1:0] word_l_q, word_l_d, word_r_q, word_r_d;
    logic              valid_q, valid_d;
    logic              ferr_q, ferr_d;
    phase_t            phase_q, phase_d;
    logic [8:0]        index_q, index_d;
    logic              bc_mid;

    // A bit count of 1..WORD_W-1 means a word is partly assembled.
    assign bc_mid = (bc_q != '0) && (bc_q != BC_FULL);

    // State register for the assembler and the load-phase FSM.
    always_ff @(posedge Sclk or negedge Reset_n) begin
        if (!Reset_n) begin
            bc_q     <= '0;
            shl_q    <= '0;
            shr_q    <= '0;
            word_l_q <= '0;
            word_r_q <= '0;
            valid_q  <= 1'b0;
            ferr_q   <= 1'b0;
            phase_q  <= PH_RJ;
            index_q  <= '0;
        end else begin
            bc_q     <= bc_d;
            shl_q    <= shl_d;
            shr_q    <= shr_d;
            word_l_q <= word_l_d;
            word_r_q <= word_r_d;
            valid_q  <= valid_d;
            ferr_q   <= ferr_d;
            phase_q  <= phase_d;
            index_q  <= index_d;
        end
    end

    // Next state: Start has priority over everything else. The index
    // advances one cycle after issue, so each word carries its own index.
    always_comb begin
        bc_d     = bc_q;
        shl_d    = shl_q;
        shr_d    = shr_q;
        word_l_d = word_l_q;
        word_r_d = word_r_q;
        valid_d  = 1'b0;
        ferr_d   = ferr_q;
        phase_d  = phase_q;
        index_d  = index_q;

        if (Start) begin
            phase_d = PH_RJ;
            index_d = '0;
            bc_d    = '0;
            shl_d   = '0;
            shr_d   = '0;
            ferr_d  = 1'b0;
        end else begin
            if (valid_q) begin
                case (phase_q)
                    PH_RJ: begin
                        if (index_q == RJ_LAST) begin
                            phase_d = PH_COEF;
                            index_d = '0;
                        end else begin
                            index_d = index_q + 9'd1;
                        end
                    end
                    PH_COEF: begin
                        if (index_q == COEF_LAST) begin
                            phase_d = PH_DATA;
                            index_d = '0;
                        end else begin
                            index_d = index_q + 9'd1;
                        end
                    end
                    default: begin
                        // Data phase is terminal. The 9-bit index wraps 511 -> 0.
                        phase_d = PH_DATA;
                        index_d = index_q + 9'd1;
                    end
                endcase
            end

            if (strobe) begin
                if (frame_s) begin
                    // A new frame restarts assembly. A partial word is lost.
                    shl_d = {{(WORD_W-1){1'b0}}, in_l_s};
                    shr_d = {{(WORD_W-1){1'b0}}, in_r_s};
                    bc_d  = BC_W'(1);
                    if (bc_mid) ferr_d = 1'b1;
                end else if (bc_mid) begin
                    shl_d = {shl_q[WORD_W-2:0], in_l_s};
                    shr_d = {shr_q[WORD_W-2:0], in_r_s};
                    bc_d  = bc_q + 1'b1;
                    if (bc_q == BC_LAST) begin
                        word_l_d = {shl_q[WORD_W-2:0], in_l_s};
                        word_r_d = {shr_q[WORD_W-2:0], in_r_s};
                        valid_d  = 1'b1;
                    end
                end
            end
        end
    end

    assign WordL     = word_l_q;
    assign WordR     = word_r_q;
    assign WordValid = valid_q;
    assign WordType  = phase_q;
    assign Index     = index_q;
    assign FrameErr  = ferr_q;

    // ------------------------------------------------------------------
    // Zero-run detector
    // ------------------------------------------------------------------
`ifdef ZERO_DETECT_EN
    localparam int              ZC_W   = $clog2(ZERO_RUN + 1);
    localparam logic [ZC_W-1:0] ZC_MAX = ZC_W'(ZERO_RUN);

    logic [ZC_W-1:0] zcnt_q, zcnt_d;
    logic            sleep_q, sleep_d;

    // Registers for the saturating zero-word counter and Sleep.
    always_ff @(posedge Sclk or negedge Reset_n) begin
        if (!Reset_n) begin
            zcnt_q  <= '0;
            sleep_q <= 1'b0;
        end else begin
            zcnt_q  <= zcnt_d;
            sleep_q <= sleep_d;
        end
    end

    // Only data words count. Any nonzero data word clears the run.
    always_comb begin
        zcnt_d  = zcnt_q;
        sleep_d = sleep_q;
        if (Start) begin
            zcnt_d  = '0;
            sleep_d = 1'b0;
        end else if (valid_q && (phase_q == PH_DATA)) begin
            if ((word_l_q == '0) && (word_r_q == '0)) begin
                if (zcnt_q != ZC_MAX) zcnt_d = zcnt_q + 1'b1;
                if (zcnt_q >= ZC_MAX - 1'b1) sleep_d = 1'b1;
            end else begin
                zcnt_d  = '0;
                sleep_d = 1'b0;
            end
        end
    end

    assign Sleep = sleep_q;
`else
    // The run length matters only when the detector is built in.
    if (ZERO_RUN < 1) begin : g_zero_run_unused
    end

    assign Sleep = 1'b0;
`endif

endmodule
